// File: rtl/spi_chain_pkg.sv
// rtl/spi_chain_pkg.sv - shared state codes and sizing helpers for the SPI chain master
package spi_chain_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;

  function automatic int total_bits(input int n_sensors, input int frame_bits);
    return n_sensors * frame_bits;
  endfunction

  function automatic logic cs_active(input int cs_pol);
    return cs_pol != 0;
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// rtl/spi_clk_gen.sv - half-period divider producing SPI_CLK and its edge strobes
module spi_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic rise_stb,
  output logic fall_stb,
  output logic sclk
);

  localparam int CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] DIV_FULL = CW'(CLK_DIV);
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sclk_q, sclk_d;
  logic          tick;

  // Idle preload of CLK_DIV gives one extra setup cycle before the first rising edge.
  always_comb begin
    tick     = en && (cnt_q == '0);
    rise_stb = tick && !sclk_q;
    fall_stb = tick && sclk_q;
    cnt_d    = DIV_FULL;
    sclk_d   = 1'b0;
    if (en) begin
      cnt_d  = tick ? DIV_LAST : cnt_q - 1'b1;
      sclk_d = tick ? ~sclk_q : sclk_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= DIV_FULL;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk = sclk_q;

endmodule

// File: rtl/spi_chain_master.sv
// rtl/spi_chain_master.sv - SPI mode-0 initiator shifting one full frame through a responder daisy chain
module spi_chain_master
  import spi_chain_pkg::*;
#(
  parameter int N_SENSORS  = 4,
  parameter int FRAME_BITS = 32,
  parameter int CLK_DIV    = 4,
  parameter int CS_POL     = 0
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic                              START,
  input  logic [N_SENSORS*FRAME_BITS-1:0]   TX_DATA,
  output logic [N_SENSORS*FRAME_BITS-1:0]   RX_DATA,
  output logic                              BUSY,
  output logic                              DONE,
  output logic                              SPI_CLK,
  output logic                              SPI_CS,
  output logic                              SPI_MOSI,
  input  logic                              SPI_MISO
);

  localparam int TOTAL = total_bits(N_SENSORS, FRAME_BITS);
  localparam int BW    = $clog2(TOTAL + 1);
  localparam int DW    = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic          CS_ON    = cs_active(CS_POL);

  logic [2:0]       state_q, state_d;
  logic [DW-1:0]    div_q, div_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [TOTAL-1:0] sr_q, sr_d;
  logic [TOTAL-1:0] rx_q, rx_d;
  logic             done_q, done_d;
  logic             cs_q, cs_d;
  logic             mosi_q, mosi_d;
  logic             sync1_q, miso_s;
  logic             fall_stb, rise_stb_unused, sclk;

  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk      (CLK),
    .rst      (RST),
    .en       (state_q == ST_SHIFT),
    .rise_stb (rise_stb_unused),
    .fall_stb (fall_stb),
    .sclk     (sclk)
  );

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    sr_d    = sr_q;
    rx_d    = rx_q;
    done_d  = 1'b0;
    mosi_d  = mosi_q;
    case (state_q)
      ST_IDLE: begin
        mosi_d = 1'b0;
        if (START) begin
          sr_d    = TX_DATA;
          bit_d   = '0;
          div_d   = DIV_LAST;
          mosi_d  = TX_DATA[TOTAL-1];
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (div_q == '0) state_d = ST_SHIFT;
        else             div_d   = div_q - 1'b1;
      end
      ST_SHIFT: begin
        // Synced MISO still holds the bit launched on the previous falling edge.
        if (fall_stb) begin
          sr_d  = {sr_q[TOTAL-2:0], miso_s};
          bit_d = bit_q + 1'b1;
          if (bit_d == BW'(TOTAL)) begin
            mosi_d  = 1'b0;
            div_d   = DIV_LAST;
            state_d = ST_HOLD;
          end else begin
            mosi_d = sr_q[TOTAL-2];
          end
        end
      end
      ST_HOLD: begin
        if (div_q == '0) begin
          rx_d    = sr_q;
          done_d  = 1'b1;
          div_d   = DIV_LAST;
          state_d = ST_GAP;
        end else begin
          div_d = div_q - 1'b1;
        end
      end
      ST_GAP: begin
        if (div_q == '0) state_d = ST_IDLE;
        else             div_d   = div_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    cs_d = (state_d == ST_SETUP || state_d == ST_SHIFT || state_d == ST_HOLD) ? CS_ON : ~CS_ON;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      sr_q    <= '0;
      rx_q    <= '0;
      done_q  <= 1'b0;
      cs_q    <= ~CS_ON;
      mosi_q  <= 1'b0;
      sync1_q <= 1'b0;
      miso_s  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      rx_q    <= rx_d;
      done_q  <= done_d;
      cs_q    <= cs_d;
      mosi_q  <= mosi_d;
      sync1_q <= SPI_MISO;
      miso_s  <= sync1_q;
    end
  end

  assign RX_DATA  = rx_q;
  assign BUSY     = (state_q != ST_IDLE);
  assign DONE     = done_q;
  assign SPI_CLK  = sclk;
  assign SPI_CS   = cs_q;
  assign SPI_MOSI = mosi_q;

endmodule

// File: tb/tb_spi_chain_master.sv
// tb/tb_spi_chain_master.sv - directed bench for spi_chain_master with two modelled 8-bit mode-0 responders
module tb_spi_chain_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] tx = '0;
  logic [15:0] rx_a, rx_b;
  logic        busy_a, done_a, sclk_a, cs_a, mosi_a, miso_a;
  logic        busy_b, done_b, sclk_b, cs_b, mosi_b, miso_b;

  logic       loop_en = 1'b0, glitch_en = 1'b0, glitch = 1'b0, preload = 1'b0, mon_clr = 1'b0;
  logic [7:0] pre_near = '0, pre_far = '0;
  logic [7:0] near_a, far_a, near_b, far_b;
  logic       cn_a, cf_a, cn_b, cf_b;

  int total = 0, bad = 0;
  int rises = 0, phase_bad = 0, cs_cyc = 0, run = 0;
  int done_cnt_a = 0;
  logic prev_sclk = 1'b0;
  int lat, d0;

  spi_chain_master #(.N_SENSORS(2), .FRAME_BITS(8), .CLK_DIV(4), .CS_POL(0)) dut_a (
    .CLK(clk), .RST(rst), .START(start), .TX_DATA(tx), .RX_DATA(rx_a), .BUSY(busy_a),
    .DONE(done_a), .SPI_CLK(sclk_a), .SPI_CS(cs_a), .SPI_MOSI(mosi_a), .SPI_MISO(miso_a)
  );

  spi_chain_master #(.N_SENSORS(2), .FRAME_BITS(8), .CLK_DIV(4), .CS_POL(1)) dut_b (
    .CLK(clk), .RST(rst), .START(start), .TX_DATA(tx), .RX_DATA(rx_b), .BUSY(busy_b),
    .DONE(done_b), .SPI_CLK(sclk_b), .SPI_CS(cs_b), .SPI_MOSI(mosi_b), .SPI_MISO(miso_b)
  );

  // Responders capture on rising SPI_CLK and shift on falling; near feeds far.
  always @(posedge sclk_a or negedge sclk_a or posedge preload) begin
    if (preload) begin
      near_a <= pre_near;
      far_a  <= pre_far;
    end else if (sclk_a) begin
      cn_a <= mosi_a;
      cf_a <= near_a[7];
    end else begin
      near_a <= {near_a[6:0], cn_a};
      far_a  <= {far_a[6:0], cf_a};
    end
  end

  always @(posedge sclk_b or negedge sclk_b or posedge preload) begin
    if (preload) begin
      near_b <= pre_near;
      far_b  <= pre_far;
    end else if (sclk_b) begin
      cn_b <= mosi_b;
      cf_b <= near_b[7];
    end else begin
      near_b <= {near_b[6:0], cn_b};
      far_b  <= {far_b[6:0], cf_b};
    end
  end

  assign miso_a = loop_en ? mosi_a : (far_a[7] ^ glitch);
  assign miso_b = far_b[7];

  always @(posedge sclk_a) begin
    if (glitch_en) begin
      #7 glitch = 1'b1;
      #9 glitch = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (done_a) done_cnt_a++;
    if (mon_clr) begin
      rises = 0; phase_bad = 0; cs_cyc = 0; run = 0;
      prev_sclk = sclk_a;
    end else begin
      if (!cs_a) cs_cyc++;
      if (sclk_a !== prev_sclk) begin
        if ((prev_sclk || rises > 0) && run != 4) phase_bad++;
        if (sclk_a) rises++;
        run = 1;
      end else begin
        run++;
      end
      prev_sclk = sclk_a;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [15:0] data);
    tx = data;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done_a && n < 400) begin
      tick();
      n++;
    end
  endtask

  task automatic load_responders(input logic [7:0] nr, input logic [7:0] fr);
    pre_near = nr;
    pre_far  = fr;
    preload  = 1'b1;
    tick();
    preload  = 1'b0;
  endtask

  initial begin
    tick(); tick(); tick();
    rst = 1'b0;
    check("rst_rx", 32'(rx_a), 32'h0);
    check("rst_busy", 32'(busy_a), 32'h0);
    check("rst_done", 32'(done_a), 32'h0);
    check("rst_sclk", 32'(sclk_a), 32'h0);
    check("rst_cs", 32'(cs_a), 32'h1);
    check("rst_mosi", 32'(mosi_a), 32'h0);
    check("rst_cs_pol1", 32'(cs_b), 32'h0);

    // Scenario 1 (and CS_POL=1 instance in parallel)
    load_responders(8'hA5, 8'h3C);
    launch(16'h1234);
    check("s1_cs_setup", 32'(cs_a), 32'h0);
    check("s1_mosi_setup", 32'(mosi_a), 32'h0);
    check("s5_cs_setup", 32'(cs_b), 32'h1);
    check("s1_busy", 32'(busy_a), 32'h1);
    wait_done(lat);
    check("s1_latency", 32'(lat), 32'd137);
    check("s1_rx", 32'(rx_a), 32'h3CA5);
    check("s1_far", 32'(far_a), 32'h12);
    check("s1_near", 32'(near_a), 32'h34);
    check("s5_rx", 32'(rx_b), 32'h3CA5);
    check("s5_far", 32'(far_b), 32'h12);
    check("s5_near", 32'(near_b), 32'h34);
    repeat (10) tick();
    check("s1_busy_end", 32'(busy_a), 32'h0);
    check("s5_cs_idle", 32'(cs_b), 32'h0);

    // Scenario 2: loopback with clock-shape monitor
    loop_en = 1'b1;
    mon_clr = 1'b1;
    tick();
    mon_clr = 1'b0;
    launch(16'hF00F);
    wait_done(lat);
    check("s2_rx", 32'(rx_a), 32'hF00F);
    check("s2_rises", 32'(rises), 32'd16);
    check("s2_phase_len", 32'(phase_bad), 32'd0);
    check("s2_cs_cycles", 32'(cs_cyc), 32'd137);
    loop_en = 1'b0;
    repeat (10) tick();

    // Scenario 3: START while busy is ignored
    load_responders(8'h11, 8'h22);
    d0 = done_cnt_a;
    launch(16'h1234);
    for (int c = 1; c <= 150; c++) begin
      start = (c == 20 || c == 100);
      if (start) tx = 16'hFFFF;
      tick();
      if (c == 100) check("s3_busy_c100", 32'(busy_a), 32'h1);
    end
    start = 1'b0;
    check("s3_done_count", 32'(done_cnt_a - d0), 32'd1);
    check("s3_idle_after", 32'(busy_a), 32'h0);

    // START on the GAP->IDLE edge is dropped; one cycle later it is honoured
    launch(16'h00FF);
    wait_done(lat);
    repeat (3) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("s3_gap_start_busy", 32'(busy_a), 32'h0);
    tick();
    check("s3_gap_start_busy2", 32'(busy_a), 32'h0);
    launch(16'h5AA5);
    check("s3_b2b_busy", 32'(busy_a), 32'h1);
    wait_done(lat);
    check("s3_b2b_latency", 32'(lat), 32'd137);
    repeat (10) tick();

    // Scenario 4: reset mid-transfer
    load_responders(8'hA5, 8'h3C);
    launch(16'h1234);
    repeat (59) tick();
    rst = 1'b1;
    tick();
    check("s4_cs", 32'(cs_a), 32'h1);
    check("s4_sclk", 32'(sclk_a), 32'h0);
    check("s4_busy", 32'(busy_a), 32'h0);
    check("s4_rx", 32'(rx_a), 32'h0);
    check("s4_mosi", 32'(mosi_a), 32'h0);
    rst = 1'b0;
    d0 = done_cnt_a;
    repeat (200) tick();
    check("s4_no_done", 32'(done_cnt_a - d0), 32'd0);
    check("s4_rx_hold", 32'(rx_a), 32'h0);

    // Scenario 6: asynchronous MISO glitch inside each high phase
    glitch_en = 1'b1;
    load_responders(8'hA5, 8'h3C);
    launch(16'h1234);
    wait_done(lat);
    check("s6_latency", 32'(lat), 32'd137);
    check("s6_rx", 32'(rx_a), 32'h3CA5);
    glitch_en = 1'b0;
    repeat (10) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_chain_master.md
Name: spi_chain_master

Overview:
- SPI initiator that drives a daisy chain of N_SENSORS sensor SPI responders sharing SPI_CLK/SPI_CS, with MOSI→MISO chained through each sensor.
- One transaction shifts a full chain frame out on SPI_MOSI and simultaneously captures the frame returned on SPI_MISO.
- Sits in the on-chip/FPGA controller, replacing the external microcontroller on the UC SPI port.

Parameters:
- N_SENSORS, 4, number of responders in the chain.
- FRAME_BITS, 32, shift-register length of one responder.
- CLK_DIV, 4, system clocks per SPI half-period; legal range ≥3.
- CS_POL, 0, active level of SPI_CS (0 = active-low).

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous active-high reset.
- START  in  1  one-cycle request; honoured only when BUSY=0.
- TX_DATA  in  N_SENSORS*FRAME_BITS  chain frame, latched on the START cycle.
- RX_DATA  out  N_SENSORS*FRAME_BITS  last received chain frame.
- BUSY  out  1  transaction in progress.
- DONE  out  1  one-cycle pulse when RX_DATA is updated.
- SPI_CLK  out  1  serial clock, CPOL=0.
- SPI_CS  out  1  chip select.
- SPI_MOSI  out  1  serial data to first responder.
- SPI_MISO  in  1  serial data from last responder; asynchronous to CLK.

Behaviour:
- Definitions: TOTAL = N_SENSORS*FRAME_BITS (a shared localparam). Mode 0 timing: data is launched on the falling edge and captured on the rising edge. Bits go MSB first.
- Reset (RST=1 at a CLK edge):
  - RX_DATA=0, BUSY=0, DONE=0, SPI_CLK=0, SPI_CS=!CS_POL, SPI_MOSI=0.
  - The FSM returns to IDLE and all counters clear.
  - Reset mid-transaction aborts the transfer on the next edge, with no DONE and RX_DATA unchanged from its reset value.
- SPI_MISO passes through a 2-flop synchroniser (miso_s).
- FSM states:
  - IDLE: outputs are at their reset values except RX_DATA. START=1 latches TX_DATA into shift register sr, sets the bit counter to 0, and moves to SETUP. BUSY=1 from the next cycle.
  - SETUP: SPI_CS is active and SPI_MOSI=sr[TOTAL-1]. The state lasts CLK_DIV cycles, then moves to SHIFT.
  - SHIFT: SPI_CLK toggles every CLK_DIV cycles, starting with a 0→1 transition.
    - Rising toggle: no datapath action.
    - Falling toggle: sr <= {sr[TOTAL-2:0], miso_s}, the bit counter increments, and SPI_MOSI takes the new sr MSB.
    - When the counter reaches TOTAL on a falling toggle, move to HOLD with SPI_CLK=0.
    - Sampling synced MISO at the falling edge returns the value the responder launched on the previous falling edge; this is valid because CLK_DIV≥3.
  - HOLD: SPI_CS remains active for CLK_DIV cycles. Then SPI_CS goes inactive, RX_DATA<=sr, DONE=1 for exactly that one cycle, and the FSM moves to GAP.
  - GAP: SPI_CS is inactive for CLK_DIV cycles, then the FSM returns to IDLE and BUSY falls.
- Latency: START sampled at edge 0 → DONE high for the cycle after edge 1+CLK_DIV*(2*TOTAL+2). BUSY falls CLK_DIV cycles later.
- Bit mapping:
  - TX_DATA[TOTAL-1 -: FRAME_BITS] lands in the farthest responder (index N_SENSORS-1).
  - TX_DATA[FRAME_BITS-1:0] lands in the responder nearest SPI_MOSI.
  - RX_DATA uses the same mapping for the contents each responder held before the transfer.
- START while BUSY=1 is ignored (no queueing). START in the same cycle that GAP→IDLE occurs is ignored.
- SPI_MOSI changes only on falling toggles or on entering SETUP. SPI_CLK has no glitches and is exactly 50% duty.

Decomposition:
- Package spi_chain_pkg: state enum {IDLE,SETUP,SHIFT,HOLD,GAP}, the TOTAL localparam function, and the CS_ACTIVE helper.
- Sub-module spi_clk_gen: half-period down-counter producing rise_stb/fall_stb and SPI_CLK, enabled only in SHIFT.

Test Plan (N_SENSORS=2, FRAME_BITS=8, CLK_DIV=4; bench models two 8-bit mode-0 responder shift registers chained MOSI→MISO):
1. Responders preloaded with 0xA5 (near) and 0x3C (far); START with TX_DATA=0x1234 → DONE after 1+4*34=137 cycles; RX_DATA=0x3CA5; responders then hold far=0x12, near=0x34.
2. Loopback (SPI_MISO tied to SPI_MOSI, no responders), TX_DATA=0xF00F → RX_DATA=0xF00F. Also check exactly 16 SPI_CLK rising edges, each high/low phase of 4 cycles, and SPI_CS low from SETUP through HOLD.
3. START pulsed again at cycles 20 and 100 of an active transfer → only one DONE occurs and the transfer count is 1. A back-to-back START after BUSY falls starts a new transfer.
4. RST asserted at cycle 60 of a transfer → next edge gives SPI_CS=1, SPI_CLK=0, BUSY=0, RX_DATA=0, and DONE never pulses.
5. CS_POL=1 build → SPI_CS idles 0 and is 1 during SETUP–HOLD; data results identical to scenario 1.
6. SPI_MISO toggled asynchronously mid-high-phase → captured bits are unchanged versus scenario 1 (no sample-window corruption).
